btn_db_edge: RTL and testbench



---
 rtl/btn_pkg.sv | 28 ++
 rtl/sample_tick_gen.sv | 28 ++
 rtl/btn_db_edge.sv | 130 +++++++++++++
 tb/tb_btn_db_edge.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning blocks.
// Debounce state encoding and the default timing used by every top level.
package btn_pkg;

    localparam logic [1:0] ST_ZERO  = 2'b00;
    localparam logic [1:0] ST_WAIT1 = 2'b01;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_WAIT0 = 2'b11;

    typedef enum logic [1:0] {
        ZERO  = ST_ZERO,
        WAIT1 = ST_WAIT1,
        ONE   = ST_ONE,
        WAIT0 = ST_WAIT0
    } db_state_e;

    // About 10.5 ms per sample tick at 50 MHz.
    localparam int DB_N_DEFAULT       = 19;
    localparam int DB_CONFIRM_DEFAULT = 3;

    localparam int CONF_W = 4;

    // Last confirm count before a new level is accepted.
    function automatic logic [CONF_W-1:0] conf_last(input int confirm);
        return CONF_W'(confirm - 1);
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample tick: one-cycle pulse every 2^N clk cycles.
// Shared by the debouncer and the display refresh multiplexer.
module sample_tick_gen
    import btn_pkg::*;
#(
    parameter int N = DB_N_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    output logic m_tick
);

    localparam logic [N-1:0] CNT_INC = N'(1);

    logic [N-1:0] cnt;

    // Wrapping counter; never disturbed by downstream activity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_INC;
        end
    end

    assign m_tick = &cnt;

endmodule

// File: rtl/btn_db_edge.sv
// Button conditioner: synchronizer, debounce FSM and event ticks.
// Produces a clean level, rise/fall ticks and a raw bounce tick.
module btn_db_edge
    import btn_pkg::*;
#(
    parameter int N          = DB_N_DEFAULT,
    parameter int CONFIRM    = DB_CONFIRM_DEFAULT,
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic db_level,
    output logic db_rise_tick,
    output logic db_fall_tick,
    output logic raw_tick
);

    localparam logic INV = (ACTIVE_LOW != 0);
    // Pin level of a released button, so sw_s resets to 0.
    localparam logic REL_PIN = INV;
    localparam logic [CONF_W-1:0] C_LAST = conf_last(CONFIRM);
    localparam logic [CONF_W-1:0] C_INC  = CONF_W'(1);

    logic                sync_q1;
    logic                sync_q2;
    logic                sw_s;
    logic                sw_d;
    logic                m_tick;
    logic                db_level_d;
    db_state_e           state;
    logic [CONF_W-1:0]   cnt_c;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= REL_PIN;
            sync_q2 <= REL_PIN;
        end else begin
            sync_q1 <= sw_raw;
            sync_q2 <= sync_q1;
        end
    end

    assign sw_s = sync_q2 ^ INV;

    // Previous synchronized level for raw edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_d <= 1'b0;
        end else begin
            sw_d <= sw_s;
        end
    end

    assign raw_tick = sw_s & ~sw_d;

    sample_tick_gen #(
        .N (N)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .m_tick (m_tick)
    );

    // Debounce FSM; a revert beats a coincident sample tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ZERO;
            cnt_c    <= '0;
            db_level <= 1'b0;
        end else begin
            unique case (state)
                ZERO: begin
                    if (sw_s) begin
                        state <= WAIT1;
                        cnt_c <= '0;
                    end
                end
                WAIT1: begin
                    if (!sw_s) begin
                        state <= ZERO;
                    end else if (m_tick) begin
                        if (cnt_c == C_LAST) begin
                            state    <= ONE;
                            db_level <= 1'b1;
                        end else begin
                            cnt_c <= cnt_c + C_INC;
                        end
                    end
                end
                ONE: begin
                    if (!sw_s) begin
                        state <= WAIT0;
                        cnt_c <= '0;
                    end
                end
                WAIT0: begin
                    if (sw_s) begin
                        state <= ONE;
                    end else if (m_tick) begin
                        if (cnt_c == C_LAST) begin
                            state    <= ZERO;
                            db_level <= 1'b0;
                        end else begin
                            cnt_c <= cnt_c + C_INC;
                        end
                    end
                end
                default: begin
                    state    <= ZERO;
                    db_level <= 1'b0;
                end
            endcase
        end
    end

    // Delayed level for the one-cycle event ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_level_d <= 1'b0;
        end else begin
            db_level_d <= db_level;
        end
    end

    assign db_rise_tick = db_level & ~db_level_d;
    assign db_fall_tick = ~db_level & db_level_d;

endmodule

// File: tb/tb_btn_db_edge.sv
// Self-checking bench for btn_db_edge at N=4, CONFIRM=3.
// Debounced ticks are scoreboarded against latency windows.
module tb_btn_db_edge;

    localparam int N = 4;
    localparam int C = 3;
    localparam int P = 1 << N;
    localparam int NV = 23;

    logic clk = 1'b0;
    logic reset;
    logic sw_raw;
    logic db_level;
    logic db_rise_tick;
    logic db_fall_tick;
    logic raw_tick;

    btn_db_edge #(
        .N          (N),
        .CONFIRM    (C),
        .ACTIVE_LOW (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_raw       (sw_raw),
        .db_level     (db_level),
        .db_rise_tick (db_rise_tick),
        .db_fall_tick (db_fall_tick),
        .raw_tick     (raw_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rise;
        int   lo;
        int   hi;
    } exp_t;

    typedef struct {
        logic sw;
        logic exp_raw;
        logic exp_lvl;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t tbl[NV];

    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   raw_cnt = 0;
    int   rise_cnt = 0;
    int   fall_cnt = 0;
    logic lvl_prev = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, got, exp, cyc);
        end
    endtask

    // Window for a debounced edge after a pin change driven at cycle d.
    function automatic void expect_db(input logic rise, input int d);
        exp_t e;
        e.rise = rise;
        e.lo   = d + 1 + 2 + (C - 1) * P + 1;
        e.hi   = d + 1 + 2 + C * P;
        sbq.push_back(e);
    endfunction

    // Monitor: pops the scoreboard whenever a debounced tick appears.
    always @(negedge clk) begin
        if (reset) begin
            lvl_prev = 1'b0;
        end else begin
            if (raw_tick) raw_cnt++;
            if (db_rise_tick && db_fall_tick)
                chk("rise_and_fall", 1, 0);
            if (db_level !== lvl_prev)
                chk("level_vs_tick", db_rise_tick | db_fall_tick, 1);
            lvl_prev = db_level;
            if (db_rise_tick || db_fall_tick) begin
                if (db_rise_tick) rise_cnt++;
                else fall_cnt++;
                if (sbq.size() == 0) begin
                    chk("unexpected_tick", {db_rise_tick, db_fall_tick}, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("tick_kind", db_rise_tick, mon_e.rise);
                    chk("tick_level", db_level, mon_e.rise);
                    chk("tick_window",
                        (cyc >= mon_e.lo) && (cyc <= mon_e.hi), 1);
                end
            end else if (sbq.size() > 0 && cyc > sbq[0].hi) begin
                chk("tick_timeout", cyc, sbq[0].hi);
                void'(sbq.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [0:NV-1] sw_pat;
        logic [0:NV-1] raw_pat;
        int r0, c0, f0;

        // Bouncy press: 5 toggles of 3 cycles after 3 released cycles.
        sw_pat  = 23'b111_000_111_000_111_00000000;
        raw_pat = 23'b00000_1_00000_1_00000_1_00000;
        for (int i = 0; i < NV; i++) begin
            tbl[i].sw      = sw_pat[i];
            tbl[i].exp_raw = raw_pat[i];
            tbl[i].exp_lvl = 1'b0;
        end

        // Reset with the button released, then idle.
        reset  = 1'b1;
        sw_raw = 1'b1;
        tick(5);
        chk("rst_level", db_level, 0);
        chk("rst_rise", db_rise_tick, 0);
        chk("rst_fall", db_fall_tick, 0);
        chk("rst_raw", raw_tick, 0);
        reset = 1'b0;
        tick(100);
        chk("idle_level", db_level, 0);
        chk("idle_raw_cnt", raw_cnt, 0);
        chk("idle_rise_cnt", rise_cnt, 0);

        // Clean press: raw tick two cycles after drive, then a rise.
        r0 = raw_cnt;
        c0 = rise_cnt;
        sw_raw = 1'b0;
        expect_db(1'b1, cyc);
        tick(1);
        chk("press_raw_d1", raw_tick, 0);
        tick(1);
        chk("press_raw_d2", raw_tick, 1);
        tick(58);
        chk("press_raw_cnt", raw_cnt - r0, 1);
        chk("press_rise_cnt", rise_cnt - c0, 1);
        chk("press_level", db_level, 1);

        // Clean release.
        f0 = fall_cnt;
        sw_raw = 1'b1;
        expect_db(1'b0, cyc);
        tick(60);
        chk("rel1_fall_cnt", fall_cnt - f0, 1);
        chk("rel1_level", db_level, 0);

        // Bouncy press from the table.
        r0 = raw_cnt;
        c0 = rise_cnt;
        for (int i = 0; i < NV; i++) begin
            tick(1);
            chk("bounce_raw", raw_tick, tbl[i].exp_raw);
            chk("bounce_level", db_level, tbl[i].exp_lvl);
            sw_raw = tbl[i].sw;
            if (i == 15) expect_db(1'b1, cyc);
        end
        tick(60);
        chk("bounce_raw_cnt", raw_cnt - r0, 3);
        chk("bounce_rise_cnt", rise_cnt - c0, 1);
        chk("bounce_level", db_level, 1);

        // Short release glitch while pressed.
        r0 = raw_cnt;
        f0 = fall_cnt;
        sw_raw = 1'b1;
        tick(10);
        sw_raw = 1'b0;
        tick(80);
        chk("glitch_level", db_level, 1);
        chk("glitch_fall_cnt", fall_cnt - f0, 0);
        chk("glitch_raw_cnt", raw_cnt - r0, 1);

        // Release held for 60 cycles.
        f0 = fall_cnt;
        sw_raw = 1'b1;
        expect_db(1'b0, cyc);
        tick(60);
        chk("rel2_fall_cnt", fall_cnt - f0, 1);
        chk("rel2_level", db_level, 0);

        // Reset mid-WAIT1 with the button kept pressed.
        c0 = rise_cnt;
        sw_raw = 1'b0;
        expect_db(1'b1, cyc);
        tick(20);
        #2 reset = 1'b1;
        #1;
        chk("arst_level", db_level, 0);
        chk("arst_rise", db_rise_tick, 0);
        chk("arst_fall", db_fall_tick, 0);
        chk("arst_raw", raw_tick, 0);
        sbq.delete();
        tick(5);
        reset = 1'b0;
        expect_db(1'b1, cyc);
        tick(32);
        chk("reconf_early_rise", rise_cnt - c0, 0);
        tick(28);
        chk("reconf_rise_cnt", rise_cnt - c0, 1);
        chk("reconf_level", db_level, 1);

        tick(2);
        chk("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
